// File: rtl/seg_digit_scanner.sv
// Multi-digit 7-segment scan controller: steps through the digits of a packed
// BCD value at a programmable rate. It drives one 4-bit code, a one-hot digit
// enable and a decimal point per digit period. Value updates take effect only
// at frame boundaries.
module seg_digit_scanner #(
  parameter int NUM_DIGITS    = 4,
  parameter int REFRESH_DIV   = 50000,
  parameter int DEADTIME      = 2,
  parameter int BLANK_LEADING = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [3:0]              bin_out,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    dp_out,
  output logic                    frame_tick
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VW = 4 * NUM_DIGITS;

  localparam logic [PW-1:0] P_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] P_DEAD = PW'(DEADTIME);
  localparam logic [IW-1:0] I_LAST = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]         prescaler;
  logic [IW-1:0]         idx;
  logic [VW-1:0]         pending;
  logic [NUM_DIGITS-1:0] pending_dp;
  logic [VW-1:0]         active;
  logic [NUM_DIGITS-1:0] active_dp;
  logic                  period_end;
  logic                  frame_end;

  // Code for the selected digit. A digit is blanked (4'hF) when it and every
  // more significant digit are zero. Digit 0 always shows, so a zero value
  // still displays a single "0".
  function automatic logic [3:0] digit_code(input logic [VW-1:0] act,
                                            input logic [IW-1:0] sel);
    logic [3:0] nib;
    logic       upper_nz;
    nib      = 4'h0;
    upper_nz = 1'b0;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (j == int'(sel))
        nib = act[4*j +: 4];
      if (j >= int'(sel) && act[4*j +: 4] != 4'h0)
        upper_nz = 1'b1;
    end
    if (BLANK_LEADING != 0 && sel != '0 && !upper_nz)
      return 4'hF;
    return nib;
  endfunction

  // Decimal point of the selected digit. It is shown even on blanked digits.
  function automatic logic digit_dp(input logic [NUM_DIGITS-1:0] dps,
                                    input logic [IW-1:0]         sel);
    logic bit_sel;
    bit_sel = 1'b0;
    for (int j = 0; j < NUM_DIGITS; j++)
      if (j == int'(sel))
        bit_sel = dps[j];
    return bit_sel;
  endfunction

  assign period_end = (prescaler == P_LAST);
  assign frame_end  = period_end && (idx == I_LAST);

  // Prescaler and digit index; frame_tick is raised alongside the return to digit 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler  <= '0;
      idx        <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_end;
      if (period_end) begin
        prescaler <= '0;
        idx       <= (idx == I_LAST) ? '0 : idx + 1'b1;
      end else begin
        prescaler <= prescaler + 1'b1;
      end
    end
  end

  // Pending buffer: the most recent load within a frame wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= '0;
      pending_dp <= '0;
    end else if (load) begin
      pending    <= value;
      pending_dp <= dp_in;
    end
  end

  // Displayed value changes only at the frame boundary; a load on that exact edge bypasses pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active    <= '0;
      active_dp <= '0;
    end else if (frame_end) begin
      active    <= load ? value : pending;
      active_dp <= load ? dp_in : pending_dp;
    end
  end

  // Outputs decoded from registered state only; enables stay off during the dead time
  always_comb begin
    digit_en = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      digit_en[i] = (int'(idx) == i) && (prescaler >= P_DEAD);
    bin_out = digit_code(active, idx);
    dp_out  = digit_dp(active_dp, idx);
  end

endmodule
